mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline.
- Consumes the EX/MEM register outputs (PC, instruction, ALU result, rt data, forwarding T_new) and owns the word-organised data memory.
- Performs aligned byte/half/word loads and stores with sign/zero extension, and registers results into the MEM/WB boundary.
- Exports the store trace used by the grading harness.

Parameters:
- DM_WORDS, 3072, data memory depth in 32-bit words (12 KiB).
- PC_RESET, 32'h0000_3000, reset value of w_pc.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- en  in  1  stage advance; 0 = hold all W-side registers and suppress stores
- m_pc  in  32  PC of the instruction in M
- m_instr  in  32  instruction in M
- m_alu  in  32  ALU result; byte address for loads/stores
- m_rt  in  32  rt data captured at EX/MEM
- m_tnew  in  3  forwarding T_new at M
- fwd_rt_sel  in  1  1 = take store data from w_fwd_data instead of m_rt
- w_fwd_data  in  32  value being written back in W (W to M forwarding)
- w_pc  out  32  PC to W
- w_instr  out  32  instruction to W
- w_alu  out  32  ALU result to W
- w_mem  out  32  extended load data to W
- w_tnew  out  3  forwarding T_new at W
- dm_we  out  1  store committed this cycle (combinational)
- dm_addr  out  32  byte address of committed store (combinational)
- dm_wdata  out  32  full merged word written (combinational)
- align_err  out  1  current M access misaligned or out of range (combinational)

Behaviour:
- Opcode = m_instr[31:26].
  - Loads: lw 0x23, lb 0x20, lbu 0x24, lh 0x21, lhu 0x25.
  - Stores: sw 0x2B, sb 0x28, sh 0x29.
  - Any other opcode performs no memory access.
- Word index = m_alu[13:2]; byte offset = m_alu[1:0].
- Bad access, which asserts align_err:
  - word access with offset != 0;
  - half access with offset[0] != 0;
  - address >= 4*DM_WORDS.
- Store data sd = fwd_rt_sel ? w_fwd_data : m_rt.
- Store merge (read-modify-write of the indexed word, little-endian lanes):
  - sw writes sd.
  - sh writes sd[15:0] into lane offset[1]*16.
  - sb writes sd[7:0] into lane offset*8.
  - Other bytes of the word are unchanged.
- Store commit:
  - A store commits at the rising edge when en=1, reset=0 and align_err=0.
  - dm_we/dm_addr/dm_wdata show the commit in that same cycle.
  - A store with en=0 or align_err=1 writes nothing and keeps dm_we=0.
  - When dm_we=0: dm_addr=0, dm_wdata=0.
- Load path:
  - Memory read is combinational from the array and registered into w_mem.
  - lw: the whole word.
  - lb/lbu: selected byte, sign-/zero-extended.
  - lh/lhu: selected half, sign-/zero-extended.
  - Non-load opcode or align_err: w_mem <= 0.
- Latency:
  - Load data appears on w_mem one cycle after the instruction is in M.
  - A store to address A at edge k is visible to a load of A in M during cycle k+1 (no stale read).
- W-side registers when en=1: w_pc<=m_pc, w_instr<=m_instr, w_alu<=m_alu, w_mem as above.
- w_tnew when en=1: w_tnew <= (m_tnew != 0) ? m_tnew-1 : 0, saturating at 0.
- en=0: all W-side registers hold their values.
- Reset:
  - w_pc=PC_RESET; w_instr, w_alu, w_mem = 0; w_tnew=0.
  - All memory words are cleared to 0 at the reset edge.
  - Reset has priority over en and over any pending store; a store present in M during reset is discarded.
  - Reset asserted mid-stream: state after the edge is identical to the power-on reset state.

Decomposition:
- Shared package mips_defs:
  - opcode constants (OP_LW..OP_SH);
  - access-size encoding (SZ_B, SZ_H, SZ_W);
  - PC_RESET value.
- One sub-module, dm_ram: a DM_WORDS x 32 array with synchronous write, combinational read, and synchronous clear on reset.
- Decode, merge, extension and the W-side registers live in mem_stage.

Test Plan:
- Reset, then idle:
  - w_pc=0x3000; w_instr, w_alu, w_mem = 0; w_tnew=0.
  - A load from 0x0 returns 0.
- sw 0x12345678 to 0x10, then lw 0x10 next cycle:
  - dm_we=1, dm_addr=0x10, dm_wdata=0x12345678.
  - w_mem=0x12345678 one cycle later.
- After the sw above, sb sd=0xAB to 0x11 -> dm_wdata=0x1234AB78.
- On word 0x1234AB78 at 0x10:
  - lb 0x11 -> 0xFFFFFFAB.
  - lbu 0x11 -> 0x000000AB.
  - lh 0x12 -> 0x00001234.
- sh to 0x13 -> align_err=1, dm_we=0, memory unchanged.
- lw from 0x3000 (out of range) -> align_err=1, w_mem=0.
- Forwarding and stall:
  - fwd_rt_sel=1, w_fwd_data=0xDEADBEEF, sw to 0x20 -> word 0x20 = 0xDEADBEEF.
  - m_tnew=2 -> w_tnew=1; m_tnew=0 -> w_tnew=0.
  - en=0 with a store in M -> no write and W-side registers held.
  - reset concurrent with sw -> no write.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: memory opcodes, access-size encoding and reset PC.
package mips_defs;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_B    = 2'd1,
    SZ_H    = 2'd2,
    SZ_W    = 2'd3
  } size_e;

  function automatic size_e op_size(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:         op_size = SZ_W;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_H;
      OP_LB, OP_LBU, OP_SB: op_size = SZ_B;
      default:              op_size = SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-organised data memory: combinational read, synchronous write, synchronous clear.
// Zero-latency read; no backpressure, writes are accepted every cycle we is high.
module dm_ram #(
  parameter int unsigned DM_WORDS = 3072,
  parameter int unsigned AW       = $clog2(DM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DM_WORDS];

  // Indices past the populated depth read as zero rather than out of bounds.
  assign rdata = (32'(addr) < DM_WORDS) ? mem[addr] : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DM_WORDS); i++) mem[i] <= 32'h0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: byte/half/word loads and stores, registered into MEM/WB.
// Loads land on w_mem one cycle later; en=0 holds W registers and suppresses stores.
module mem_stage
  import mips_defs::*;
#(
  parameter int unsigned DM_WORDS = 3072,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_instr,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_rt,
  input  logic [2:0]  m_tnew,
  input  logic        fwd_rt_sel,
  input  logic [31:0] w_fwd_data,
  output logic [31:0] w_pc,
  output logic [31:0] w_instr,
  output logic [31:0] w_alu,
  output logic [31:0] w_mem,
  output logic [2:0]  w_tnew,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        align_err
);

  localparam int unsigned AW = $clog2(DM_WORDS);

  logic [5:0]    op;
  logic [1:0]    offset;
  logic [AW-1:0] widx;
  size_e         size;
  logic          is_load;
  logic          is_store;
  logic          misalign;
  logic          out_of_range;
  logic          store_go;
  logic [31:0]   sd;
  logic [31:0]   rdata;
  logic [31:0]   merged;
  logic [31:0]   load_val;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign op       = m_instr[31:26];
  assign offset   = m_alu[1:0];
  assign widx     = m_alu[AW+1:2];
  assign size     = op_size(op);
  assign is_load  = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
                    (op == OP_LH) || (op == OP_LHU);
  assign is_store = (op == OP_SW) || (op == OP_SB) || (op == OP_SH);

  assign misalign     = ((size == SZ_W) && (offset != 2'd0)) ||
                        ((size == SZ_H) && offset[0]);
  assign out_of_range = m_alu >= 4 * DM_WORDS;
  assign align_err    = (is_load || is_store) && (misalign || out_of_range);

  assign sd       = fwd_rt_sel ? w_fwd_data : m_rt;
  assign store_go = is_store && en && !reset && !align_err;

  dm_ram #(.DM_WORDS(DM_WORDS), .AW(AW)) u_dm_ram (
    .clk   (clk),
    .reset (reset),
    .we    (store_go),
    .addr  (widx),
    .wdata (merged),
    .rdata (rdata)
  );

  // Read-modify-write: only the addressed lanes of the current word change.
  always_comb begin
    merged = rdata;
    case (size)
      SZ_W:    merged = sd;
      SZ_H:    merged[16*offset[1] +: 16] = sd[15:0];
      SZ_B:    merged[8*offset +: 8]      = sd[7:0];
      default: merged = rdata;
    endcase
  end

  assign dm_we    = store_go;
  assign dm_addr  = store_go ? m_alu  : 32'h0;
  assign dm_wdata = store_go ? merged : 32'h0;

  assign byte_sel = rdata[8*offset +: 8];
  assign half_sel = rdata[16*offset[1] +: 16];

  always_comb begin
    load_val = 32'h0;
    if (!align_err) begin
      case (op)
        OP_LW:   load_val = rdata;
        OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
        OP_LBU:  load_val = {24'h0, byte_sel};
        OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
        OP_LHU:  load_val = {16'h0, half_sel};
        default: load_val = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_pc    <= PC_RESET;
      w_instr <= 32'h0;
      w_alu   <= 32'h0;
      w_mem   <= 32'h0;
      w_tnew  <= 3'd0;
    end else if (en) begin
      w_pc    <= m_pc;
      w_instr <= m_instr;
      w_alu   <= m_alu;
      w_mem   <= load_val;
      w_tnew  <= (m_tnew != 3'd0) ? m_tnew - 3'd1 : 3'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with a cycle-tagged scoreboard.
module tb_mem_stage;

  localparam logic [5:0] LW = 6'h23, LB = 6'h20, LBU = 6'h24, LH = 6'h21, LHU = 6'h25;
  localparam logic [5:0] SW = 6'h2B, SB = 6'h28, SH = 6'h29, NOP = 6'h00;

  logic        clk, reset, en, fwd_rt_sel;
  logic [31:0] m_pc, m_instr, m_alu, m_rt, w_fwd_data;
  logic [2:0]  m_tnew;
  logic [31:0] w_pc, w_instr, w_alu, w_mem, dm_addr, dm_wdata;
  logic [2:0]  w_tnew;
  logic        dm_we, align_err;

  mem_stage dut (
    .clk(clk), .reset(reset), .en(en),
    .m_pc(m_pc), .m_instr(m_instr), .m_alu(m_alu), .m_rt(m_rt),
    .m_tnew(m_tnew), .fwd_rt_sel(fwd_rt_sel), .w_fwd_data(w_fwd_data),
    .w_pc(w_pc), .w_instr(w_instr), .w_alu(w_alu), .w_mem(w_mem),
    .w_tnew(w_tnew), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .align_err(align_err)
  );

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } comb_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [2:0]  tnew;
  } w_t;

  comb_t qc[$];
  w_t    qw[$];
  w_t    ew;
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  logic [31:0] pc_ctr = 32'h0000_4000;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: compare whatever the scoreboard expects for the current cycle.
  always @(negedge clk) begin
    comb_t c;
    w_t    w;
    while (qc.size() > 0 && qc[0].cyc == cyc) begin
      c = qc.pop_front();
      chk("dm_we",     {31'h0, dm_we},     {31'h0, c.we});
      chk("dm_addr",   dm_addr,            c.addr);
      chk("dm_wdata",  dm_wdata,           c.wdata);
      chk("align_err", {31'h0, align_err}, {31'h0, c.err});
    end
    while (qw.size() > 0 && qw[0].cyc == cyc) begin
      w = qw.pop_front();
      chk("w_pc",    w_pc,             w.pc);
      chk("w_instr", w_instr,          w.instr);
      chk("w_alu",   w_alu,            w.alu);
      chk("w_mem",   w_mem,            w.mem);
      chk("w_tnew",  {29'h0, w_tnew},  {29'h0, w.tnew});
    end
  end

  task automatic step(input logic e, input logic r, input logic [5:0] op,
                      input logic [31:0] alu, input logic [31:0] rt, input logic [2:0] tn,
                      input logic fs, input logic [31:0] fd,
                      input logic xwe, input logic [31:0] xaddr, input logic [31:0] xwdata,
                      input logic xerr, input logic [31:0] xmem, input logic [2:0] xtn);
    @(posedge clk);
    #1;
    pc_ctr     = pc_ctr + 32'd4;
    en         = e;
    reset      = r;
    m_pc       = pc_ctr;
    m_instr    = {op, 26'h0000123};
    m_alu      = alu;
    m_rt       = rt;
    m_tnew     = tn;
    fwd_rt_sel = fs;
    w_fwd_data = fd;
    qc.push_back('{cyc, xwe, xaddr, xwdata, xerr});
    if (r) begin
      ew = '{cyc + 1, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 3'd0};
    end else if (e) begin
      ew = '{cyc + 1, m_pc, m_instr, alu, xmem, xtn};
    end else begin
      ew.cyc = cyc + 1;
    end
    qw.push_back(ew);
  endtask

  initial begin
    en = 0; reset = 1; m_pc = 0; m_instr = 0; m_alu = 0; m_rt = 0;
    m_tnew = 0; fwd_rt_sel = 0; w_fwd_data = 0;
    ew = '{0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0};

    //    en r  op   alu           rt            tn fs fd            we addr          wdata         err mem           tnew
    step(1, 1, NOP, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0);
    step(1, 1, NOP, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0);
    step(1, 0, NOP, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0);
    step(1, 0, LW,  32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0);
    step(1, 0, SW,  32'h10,       32'h12345678, 0, 0, 32'h0,        1, 32'h10,       32'h12345678, 0, 32'h0,        0);
    step(1, 0, LW,  32'h10,       32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h12345678, 0);
    step(1, 0, SB,  32'h11,       32'hFFFFFFAB, 0, 0, 32'h0,        1, 32'h11,       32'h1234AB78, 0, 32'h0,        0);
    step(1, 0, LB,  32'h11,       32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'hFFFFFFAB, 0);
    step(1, 0, LBU, 32'h11,       32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h000000AB, 0);
    step(1, 0, LH,  32'h12,       32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h00001234, 0);
    step(1, 0, LH,  32'h10,       32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'hFFFFAB78, 0);
    step(1, 0, SH,  32'h13,       32'h00005555, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        0);
    step(1, 0, SW,  32'h12,       32'h00005555, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        0);
    step(1, 0, LW,  32'h10,       32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h1234AB78, 0);
    step(1, 0, LW,  32'h3000,     32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        0);
    step(1, 0, LW,  32'h2FFC,     32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0);
    step(1, 0, SW,  32'h20,       32'h11111111, 0, 1, 32'hDEADBEEF, 1, 32'h20,       32'hDEADBEEF, 0, 32'h0,        0);
    step(1, 0, LW,  32'h20,       32'h0,        2, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'hDEADBEEF, 1);
    step(1, 0, LHU, 32'h12,       32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h00001234, 0);
    step(1, 0, LW,  32'h10,       32'h0,        5, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h1234AB78, 4);
    step(0, 0, SW,  32'h24,       32'h00000099, 1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0);
    step(1, 0, LW,  32'h24,       32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0);
    step(1, 1, SW,  32'h28,       32'h00000077, 3, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0);
    step(1, 0, LW,  32'h28,       32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0);
    step(1, 0, LW,  32'h10,       32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0);
    step(1, 0, SH,  32'h22,       32'h1234CAFE, 0, 0, 32'h0,        1, 32'h22,       32'hCAFE0000, 0, 32'h0,        0);
    step(1, 0, LW,  32'h20,       32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'hCAFE0000, 0);
    step(1, 0, NOP, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0);

    for (int i = 0; i < 20 && (qc.size() > 0 || qw.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (qc.size() > 0 || qw.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d comb and %0d W entries left, expected 0", qc.size(), qw.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
